// File: rtl/mem_stage_lsu_pkg.sv
// Shared definitions for the MEM-stage load/store unit.
// Holds the funct3 access-size codes, the FSM state encoding and the
// legality/alignment helpers used by the LSU control logic.
package mem_pkg;

    // funct3 encodings for RV32 loads and stores
    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

    // Stores have no unsigned variants, so BU/HU are only legal for loads.
    function automatic logic f3_legal(input logic [2:0] f3, input logic is_store);
        logic ok;
        ok = (f3 == F3_B) || (f3 == F3_H) || (f3 == F3_W);
        if (!is_store) begin
            ok = ok || (f3 == F3_BU) || (f3 == F3_HU);
        end
        return ok;
    endfunction

    // Halfwords need an even address, words a 4-byte aligned one.
    function automatic logic addr_aligned(input logic [2:0] f3, input logic [1:0] off);
        logic ok;
        case (f3)
            F3_H, F3_HU: ok = ~off[0];
            F3_W:        ok = (off == 2'b00);
            default:     ok = 1'b1;
        endcase
        return ok;
    endfunction

endpackage

// File: rtl/mem_stage_lsu_if.sv
// Data-memory request bus between the LSU (master) and data memory (slave).
// Ports: req/we/addr/wdata/be travel master->slave; ready/rdata travel back.
// Request is held stable by the master until the slave returns ready.
interface mem_stage_lsu_if;
    logic        dmem_req;
    logic        dmem_we;
    logic [31:0] dmem_addr;
    logic [31:0] dmem_wdata;
    logic [3:0]  dmem_be;
    logic        dmem_ready;
    logic [31:0] dmem_rdata;

    modport master (
        output dmem_req, dmem_we, dmem_addr, dmem_wdata, dmem_be,
        input  dmem_ready, dmem_rdata
    );

    modport slave (
        input  dmem_req, dmem_we, dmem_addr, dmem_wdata, dmem_be,
        output dmem_ready, dmem_rdata
    );
endinterface

// File: rtl/mem_stage_lsu_align.sv
// Byte-lane steering for stores and extraction/extension for loads.
// Latency: purely combinational, zero cycles.
// Backpressure: none; the caller decides when results are used.
// Ports: st_* in -> st_be/st_wdata out (store side);
//        ld_funct3/ld_offset/ld_rdata in -> ld_data out (load side).
module lsu_align
    import mem_pkg::*;
(
    input  logic [2:0]  st_funct3,
    input  logic [1:0]  st_offset,
    input  logic [31:0] st_data,
    output logic [3:0]  st_be,
    output logic [31:0] st_wdata,
    input  logic [2:0]  ld_funct3,
    input  logic [1:0]  ld_offset,
    input  logic [31:0] ld_rdata,
    output logic [31:0] ld_data
);

    logic [7:0]  ld_byte;
    logic [15:0] ld_half;

    // Store data is replicated across lanes so the memory only needs the
    // byte enables to pick the right bytes out of the word.
    always_comb begin
        st_be    = 4'b0000;
        st_wdata = st_data;
        case (st_funct3)
            F3_B: begin
                st_be    = 4'b0001 << st_offset;
                st_wdata = {4{st_data[7:0]}};
            end
            F3_H: begin
                st_be    = 4'b0011 << st_offset;
                st_wdata = {2{st_data[15:0]}};
            end
            F3_W: begin
                st_be    = 4'b1111;
                st_wdata = st_data;
            end
            default: begin
                st_be    = 4'b0000;
                st_wdata = st_data;
            end
        endcase
    end

    always_comb begin
        ld_byte = ld_rdata[7:0];
        case (ld_offset)
            2'd0: ld_byte = ld_rdata[7:0];
            2'd1: ld_byte = ld_rdata[15:8];
            2'd2: ld_byte = ld_rdata[23:16];
            2'd3: ld_byte = ld_rdata[31:24];
            default: ld_byte = ld_rdata[7:0];
        endcase
        // Halfwords are already known to be aligned, so only bit 1 matters.
        ld_half = ld_offset[1] ? ld_rdata[31:16] : ld_rdata[15:0];
    end

    always_comb begin
        ld_data = ld_rdata;
        case (ld_funct3)
            F3_B:    ld_data = {{24{ld_byte[7]}}, ld_byte};
            F3_BU:   ld_data = {24'b0, ld_byte};
            F3_H:    ld_data = {{16{ld_half[15]}}, ld_half};
            F3_HU:   ld_data = {16'b0, ld_half};
            F3_W:    ld_data = ld_rdata;
            default: ld_data = ld_rdata;
        endcase
    end

endmodule

// File: rtl/mem_stage_lsu.sv
// MEM-stage load/store unit: issues one data-memory access per load/store,
// steers store lanes, extends load data for MEM/WB and stalls upstream stages.
// Latency: 3 cycles minimum (IDLE, BUSY with ready, DONE); +1 per wait cycle.
// Backpressure: stall_out holds PC..EX/MEM from access start until DONE;
//   a silent memory is abandoned after TIMEOUT_CYCLES with bus_error_out.
// Ports: clk/reset; EX/MEM inputs mem_read_in, mem_write_in, funct3_in,
//   addr_in, store_data_in; dmem master bus; read_data_out, stall_out,
//   misaligned_out and bus_error_out towards MEM/WB and the hazard logic.
module mem_stage_lsu
    import mem_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = 16,
    parameter int unsigned TO_W           = 5
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   mem_read_in,
    input  logic                   mem_write_in,
    input  logic [2:0]             funct3_in,
    input  logic [31:0]            addr_in,
    input  logic [31:0]            store_data_in,
    mem_stage_lsu_if.master        dmem,
    output logic [31:0]            read_data_out,
    output logic                   stall_out,
    output logic                   misaligned_out,
    output logic                   bus_error_out
);

    state_t            state_q, state_d;
    logic [TO_W-1:0]   cnt_q, cnt_d;
    logic [TO_W-1:0]   cnt_inc;
    logic              req_q, req_d;
    logic              we_q, we_d;
    logic [31:0]       addr_q, addr_d;
    logic [31:0]       wdata_q, wdata_d;
    logic [3:0]        be_q, be_d;
    logic [2:0]        f3_q, f3_d;
    logic [1:0]        off_q, off_d;
    logic [31:0]       rdout_q, rdout_d;
    logic              mis_q, mis_d;
    logic              berr_q, berr_d;

    logic              access;
    logic              is_store;
    logic              access_ok;
    logic [3:0]        st_be;
    logic [31:0]       st_wdata;
    logic [31:0]       ld_data;

    // A simultaneous read+write is resolved as a store.
    assign access    = mem_read_in | mem_write_in;
    assign is_store  = mem_write_in;
    assign access_ok = f3_legal(funct3_in, is_store) &
                       addr_aligned(funct3_in, addr_in[1:0]);
    assign cnt_inc   = cnt_q + 1'b1;

    // Store lanes come from the live EX/MEM inputs (used in IDLE only);
    // load extension uses the latched funct3/offset against returned data.
    lsu_align u_align (
        .st_funct3 (funct3_in),
        .st_offset (addr_in[1:0]),
        .st_data   (store_data_in),
        .st_be     (st_be),
        .st_wdata  (st_wdata),
        .ld_funct3 (f3_q),
        .ld_offset (off_q),
        .ld_rdata  (dmem.dmem_rdata),
        .ld_data   (ld_data)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            req_q   <= 1'b0;
            we_q    <= 1'b0;
            addr_q  <= 32'b0;
            wdata_q <= 32'b0;
            be_q    <= 4'b0;
            f3_q    <= 3'b0;
            off_q   <= 2'b0;
            rdout_q <= 32'b0;
            mis_q   <= 1'b0;
            berr_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            req_q   <= req_d;
            we_q    <= we_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            be_q    <= be_d;
            f3_q    <= f3_d;
            off_q   <= off_d;
            rdout_q <= rdout_d;
            mis_q   <= mis_d;
            berr_q  <= berr_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        req_d   = req_q;
        we_d    = we_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        be_d    = be_q;
        f3_d    = f3_q;
        off_d   = off_q;
        rdout_d = rdout_q;
        mis_d   = 1'b0;
        berr_d  = 1'b0;

        case (state_q)
            IDLE: begin
                if (access) begin
                    if (access_ok) begin
                        addr_d  = {addr_in[31:2], 2'b00};
                        // Reads leave be/wdata at zero; the memory returns a full word.
                        be_d    = is_store ? st_be : 4'b0000;
                        wdata_d = is_store ? st_wdata : 32'b0;
                        we_d    = is_store;
                        f3_d    = funct3_in;
                        off_d   = addr_in[1:0];
                        req_d   = 1'b1;
                        cnt_d   = '0;
                        state_d = BUSY;
                    end else begin
                        mis_d   = 1'b1;
                        rdout_d = 32'b0;
                    end
                end
            end
            BUSY: begin
                if (dmem.dmem_ready) begin
                    req_d   = 1'b0;
                    if (!we_q) begin
                        rdout_d = ld_data;
                    end
                    state_d = DONE;
                end else begin
                    cnt_d = cnt_inc;
                    // cnt_inc counts this cycle, so BUSY lasts exactly TIMEOUT_CYCLES.
                    if (cnt_inc == TO_W'(TIMEOUT_CYCLES)) begin
                        req_d   = 1'b0;
                        berr_d  = 1'b1;
                        rdout_d = 32'b0;
                        state_d = DONE;
                    end
                end
            end
            DONE: begin
                cnt_d   = '0;
                state_d = IDLE;
            end
            default: begin
                req_d   = 1'b0;
                cnt_d   = '0;
                state_d = IDLE;
            end
        endcase
    end

    // Gated by reset so upstream is released the instant the access is abandoned,
    // even while EX/MEM still presents the load/store.
    assign stall_out = ~reset &
                       (((state_q == IDLE) & access & access_ok) | (state_q == BUSY));

    assign dmem.dmem_req   = req_q;
    assign dmem.dmem_we    = we_q;
    assign dmem.dmem_addr  = addr_q;
    assign dmem.dmem_wdata = wdata_q;
    assign dmem.dmem_be    = be_q;

    assign read_data_out  = rdout_q;
    assign misaligned_out = mis_q;
    assign bus_error_out  = berr_q;

endmodule

// File: tb/tb_mem_stage_lsu.sv
module tb_mem_stage_lsu;

    logic        clk;
    logic        reset;
    logic        mem_read_in;
    logic        mem_write_in;
    logic [2:0]  funct3_in;
    logic [31:0] addr_in;
    logic [31:0] store_data_in;
    logic [31:0] read_data_out;
    logic        stall_out;
    logic        misaligned_out;
    logic        bus_error_out;

    mem_stage_lsu_if dmem_bus ();

    mem_stage_lsu #(
        .TIMEOUT_CYCLES (16),
        .TO_W           (5)
    ) dut (
        .clk            (clk),
        .reset          (reset),
        .mem_read_in    (mem_read_in),
        .mem_write_in   (mem_write_in),
        .funct3_in      (funct3_in),
        .addr_in        (addr_in),
        .store_data_in  (store_data_in),
        .dmem           (dmem_bus),
        .read_data_out  (read_data_out),
        .stall_out      (stall_out),
        .misaligned_out (misaligned_out),
        .bus_error_out  (bus_error_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic        rd;
        logic        wr;
        logic [2:0]  f3;
        logic [31:0] addr;
        logic [31:0] sdata;
        logic [31:0] rdata;
        logic        mis;
        logic [3:0]  be;
        logic [31:0] wdata;
        logic [31:0] exp_rd;
    } vec_t;

    localparam int NV = 14;
    vec_t        vecs [NV];
    int          checks;
    int          errors;
    logic [31:0] last_rd;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        mem_read_in   = 1'b0;
        mem_write_in  = 1'b0;
        funct3_in     = 3'b000;
        addr_in       = 32'b0;
        store_data_in = 32'b0;
    endtask

    // Presents one EX/MEM access, answers it on the first BUSY cycle and
    // holds the inputs through DONE like a frozen pipeline would.
    task automatic run_access(input vec_t v, input string tag);
        logic [31:0] exp_addr;
        logic [31:0] exp_out;
        exp_addr = {v.addr[31:2], 2'b00};
        mem_read_in   = v.rd;
        mem_write_in  = v.wr;
        funct3_in     = v.f3;
        addr_in       = v.addr;
        store_data_in = v.sdata;
        dmem_bus.dmem_ready = 1'b0;
        dmem_bus.dmem_rdata = 32'b0;
        #1;
        chk({tag, " stall_idle"}, {31'b0, stall_out}, {31'b0, ~v.mis});
        step();
        if (v.mis) begin
            chk({tag, " mis_pulse"}, {31'b0, misaligned_out}, 32'd1);
            chk({tag, " mis_noreq"}, {31'b0, dmem_bus.dmem_req}, 32'd0);
            chk({tag, " mis_rdout"}, read_data_out, 32'b0);
            last_rd = 32'b0;
            clear_inputs();
            #1;
            chk({tag, " mis_stall"}, {31'b0, stall_out}, 32'd0);
            step();
            chk({tag, " mis_once"}, {31'b0, misaligned_out}, 32'd0);
        end else begin
            chk({tag, " req"}, {31'b0, dmem_bus.dmem_req}, 32'd1);
            chk({tag, " we"}, {31'b0, dmem_bus.dmem_we}, {31'b0, v.wr});
            chk({tag, " addr"}, dmem_bus.dmem_addr, exp_addr);
            chk({tag, " be"}, {28'b0, dmem_bus.dmem_be}, {28'b0, v.be});
            if (v.wr) chk({tag, " wdata"}, dmem_bus.dmem_wdata, v.wdata);
            chk({tag, " stall_busy"}, {31'b0, stall_out}, 32'd1);
            dmem_bus.dmem_ready = 1'b1;
            dmem_bus.dmem_rdata = v.rdata;
            step();
            dmem_bus.dmem_ready = 1'b0;
            dmem_bus.dmem_rdata = 32'b0;
            exp_out = v.wr ? last_rd : v.exp_rd;
            chk({tag, " done_req"}, {31'b0, dmem_bus.dmem_req}, 32'd0);
            chk({tag, " done_stall"}, {31'b0, stall_out}, 32'd0);
            chk({tag, " rdout"}, read_data_out, exp_out);
            last_rd = exp_out;
            step();
            chk({tag, " no_reissue"}, {31'b0, dmem_bus.dmem_req}, 32'd0);
            clear_inputs();
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        vec_t lw;
        int   busy_cnt;
        logic seen_err;
        checks  = 0;
        errors  = 0;
        last_rd = 32'b0;

        //                 rd    wr    f3      addr          sdata         rdata         mis   be       wdata         exp_rd
        vecs[0]  = '{1'b1, 1'b0, 3'b000, 32'h0000_0103, 32'h0,        32'h80FF_1234, 1'b0, 4'b0000, 32'h0,        32'hFFFF_FF80};
        vecs[1]  = '{1'b1, 1'b0, 3'b101, 32'h0000_0202, 32'h0,        32'hBEEF_0001, 1'b0, 4'b0000, 32'h0,        32'h0000_BEEF};
        vecs[2]  = '{1'b1, 1'b0, 3'b001, 32'h0000_0202, 32'h0,        32'hBEEF_0001, 1'b0, 4'b0000, 32'h0,        32'hFFFF_BEEF};
        vecs[3]  = '{1'b0, 1'b1, 3'b000, 32'h0000_0301, 32'h0000_00A5, 32'h0,        1'b0, 4'b0010, 32'hA5A5_A5A5, 32'h0};
        vecs[4]  = '{1'b0, 1'b1, 3'b001, 32'h0000_0302, 32'hABCD_1234, 32'h0,        1'b0, 4'b1100, 32'h1234_1234, 32'h0};
        vecs[5]  = '{1'b1, 1'b0, 3'b010, 32'h0000_0405, 32'h0,        32'h0,        1'b1, 4'b0000, 32'h0,        32'h0};
        vecs[6]  = '{1'b1, 1'b0, 3'b010, 32'h0000_0408, 32'h0,        32'hDEAD_BEEF, 1'b0, 4'b0000, 32'h0,        32'hDEAD_BEEF};
        vecs[7]  = '{1'b1, 1'b0, 3'b100, 32'h0000_0102, 32'h0,        32'h80FF_1234, 1'b0, 4'b0000, 32'h0,        32'h0000_00FF};
        vecs[8]  = '{1'b0, 1'b1, 3'b010, 32'h0000_050C, 32'hCAFE_F00D, 32'h0,        1'b0, 4'b1111, 32'hCAFE_F00D, 32'h0};
        vecs[9]  = '{1'b1, 1'b0, 3'b001, 32'h0000_0201, 32'h0,        32'h0,        1'b1, 4'b0000, 32'h0,        32'h0};
        vecs[10] = '{1'b0, 1'b1, 3'b100, 32'h0000_0300, 32'h0000_0011, 32'h0,        1'b1, 4'b0000, 32'h0,        32'h0};
        vecs[11] = '{1'b1, 1'b1, 3'b000, 32'h0000_0600, 32'h1234_567E, 32'h5555_5555, 1'b0, 4'b0001, 32'h7E7E_7E7E, 32'h0};
        vecs[12] = '{1'b1, 1'b0, 3'b011, 32'h0000_0610, 32'h0,        32'h0,        1'b1, 4'b0000, 32'h0,        32'h0};
        vecs[13] = '{1'b1, 1'b0, 3'b001, 32'h0000_0206, 32'h0,        32'h7FFF_8000, 1'b0, 4'b0000, 32'h0,        32'h0000_7FFF};

        // Reset state
        clear_inputs();
        dmem_bus.dmem_ready = 1'b0;
        dmem_bus.dmem_rdata = 32'b0;
        reset = 1'b1;
        step();
        step();
        chk("rst req", {31'b0, dmem_bus.dmem_req}, 32'd0);
        chk("rst we", {31'b0, dmem_bus.dmem_we}, 32'd0);
        chk("rst addr", dmem_bus.dmem_addr, 32'b0);
        chk("rst wdata", dmem_bus.dmem_wdata, 32'b0);
        chk("rst be", {28'b0, dmem_bus.dmem_be}, 32'b0);
        chk("rst rdout", read_data_out, 32'b0);
        chk("rst stall", {31'b0, stall_out}, 32'd0);
        chk("rst mis", {31'b0, misaligned_out}, 32'd0);
        chk("rst berr", {31'b0, bus_error_out}, 32'd0);
        reset = 1'b0;
        step();

        for (int i = 0; i < NV; i++) begin
            run_access(vecs[i], $sformatf("v%0d", i));
        end

        // Reset in the middle of a waiting load
        lw = '{1'b1, 1'b0, 3'b010, 32'h0000_0800, 32'h0, 32'h0, 1'b0, 4'b0000, 32'h0, 32'h0};
        mem_read_in = lw.rd;
        funct3_in   = lw.f3;
        addr_in     = lw.addr;
        step();
        step();
        step();
        chk("midrst busy", {31'b0, dmem_bus.dmem_req}, 32'd1);
        #2;
        reset = 1'b1;
        #1;
        chk("midrst req", {31'b0, dmem_bus.dmem_req}, 32'd0);
        chk("midrst stall", {31'b0, stall_out}, 32'd0);
        chk("midrst rdout", read_data_out, 32'b0);
        chk("midrst addr", dmem_bus.dmem_addr, 32'b0);
        chk("midrst be", {28'b0, dmem_bus.dmem_be}, 32'b0);
        chk("midrst we", {31'b0, dmem_bus.dmem_we}, 32'd0);
        chk("midrst mis", {31'b0, misaligned_out}, 32'd0);
        chk("midrst berr", {31'b0, bus_error_out}, 32'd0);
        clear_inputs();
        last_rd = 32'b0;
        step();
        reset = 1'b0;
        step();
        lw = '{1'b1, 1'b0, 3'b010, 32'h0000_0900, 32'h0, 32'h1357_9BDF, 1'b0, 4'b0000, 32'h0, 32'h1357_9BDF};
        run_access(lw, "post_rst");

        // Non-memory instructions with a stray ready: no request, no stall
        dmem_bus.dmem_ready = 1'b1;
        dmem_bus.dmem_rdata = 32'hFFFF_FFFF;
        for (int c = 0; c < 3; c++) begin
            #1;
            chk($sformatf("nop%0d stall", c), {31'b0, stall_out}, 32'd0);
            step();
            chk($sformatf("nop%0d req", c), {31'b0, dmem_bus.dmem_req}, 32'd0);
            chk($sformatf("nop%0d rdout", c), read_data_out, last_rd);
        end
        dmem_bus.dmem_ready = 1'b0;
        dmem_bus.dmem_rdata = 32'b0;

        // Timeout: memory never answers
        mem_read_in = 1'b1;
        funct3_in   = 3'b010;
        addr_in     = 32'h0000_0700;
        step();
        busy_cnt = 0;
        seen_err = 1'b0;
        for (int c = 0; c < 40; c++) begin
            if (bus_error_out) begin
                seen_err = 1'b1;
                break;
            end
            if (stall_out && dmem_bus.dmem_req) busy_cnt++;
            step();
        end
        chk("to seen", {31'b0, seen_err}, 32'd1);
        chk("to busy_cycles", busy_cnt, 32'd16);
        chk("to rdout", read_data_out, 32'b0);
        chk("to req", {31'b0, dmem_bus.dmem_req}, 32'd0);
        chk("to stall", {31'b0, stall_out}, 32'd0);
        step();
        chk("to berr_once", {31'b0, bus_error_out}, 32'd0);
        chk("to idle_noreq", {31'b0, dmem_bus.dmem_req}, 32'd0);
        clear_inputs();
        step();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
